// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory-address mux and mem_responder.
// The master modport is the core side; the slave modport is the responder side.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder for the multicycle RV32I core.
// Define MEM_RESPONDER_CHECK_EN to flag misaligned/out-of-range addresses via rsp_err.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [3:0]          count;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_idx;
  logic [31:0]         lat_wdata;
  logic [3:0]          lat_be;
  logic                lat_err;
  logic                addr_err;
  logic                commit_write;

  logic [31:0] mem [2**ADDR_W];

`ifdef MEM_RESPONDER_CHECK_EN
  assign addr_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:ADDR_W+2] != '0);
`else
  // Unused address bits are dropped so accesses wrap modulo the array depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[1:0], bus.req_addr[31:ADDR_W+2]};
  assign addr_err = 1'b0;
`endif

  assign commit_write = (state == ACCESS) && (count == 4'd0) && lat_write && !lat_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= 4'd0;
      lat_write     <= 1'b0;
      lat_idx       <= '0;
      lat_wdata     <= 32'd0;
      lat_be        <= 4'd0;
      lat_err       <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write     <= bus.req_write;
            lat_idx       <= bus.req_addr[ADDR_W+1:2];
            lat_wdata     <= bus.req_wdata;
            lat_be        <= bus.req_be;
            lat_err       <= addr_err;
            count         <= 4'(LATENCY - 1);
            state         <= ACCESS;
            bus.req_ready <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            busy          <= 1'b1;
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= lat_err;
            bus.rsp_rdata <= (lat_write || lat_err) ? 32'd0 : mem[lat_idx];
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          // Returning to IDLE guarantees one idle cycle before the next accept.
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  // Array contents are not reset, so the storage lives in its own clock-only block.
  always_ff @(posedge clk) begin
    if (commit_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 main instance plus a LATENCY=1 instance
// for back-to-back accept spacing. Error-check vectors follow MEM_RESPONDER_CHECK_EN.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic fast_busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_responder_if bus();
  mem_responder_if fast_bus();

  mem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  mem_responder #(.ADDR_W(10), .LATENCY(1)) u_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (fast_bus),
    .busy  (fast_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input string tag);
    checkOutput({tag, "_accept_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = ~write;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;
    bus.req_be    = ~be;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_ready_low"}, 32'(bus.req_ready), 32'd0);
  endtask

  task automatic waitResponse(output int cycles);
    cycles = 0;
    while (!bus.rsp_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic transaction(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                             input int hold, input string tag);
    int cycles;
    applyStimulus(write, addr, wdata, be, tag);
    waitResponse(cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd2);
    checkOutput({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rdata);
      checkOutput({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cycles;
    int accepts[$];

    reset              = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_addr       = 32'd0;
    bus.req_wdata      = 32'd0;
    bus.req_be         = 4'd0;
    bus.rsp_ready      = 1'b0;
    fast_bus.req_valid = 1'b0;
    fast_bus.req_write = 1'b0;
    fast_bus.req_addr  = 32'h40;
    fast_bus.req_wdata = 32'd0;
    fast_bus.req_be    = 4'd0;
    fast_bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] basic write/read");
    transaction(1'b1, 32'h40, 32'hDEADBEEF, 4'b1111, 32'd0, 1'b0, 0, "wr_full");
    transaction(1'b0, 32'h40, 32'd0, 4'b0000, 32'hDEADBEEF, 1'b0, 0, "rd_full");
    transaction(1'b1, 32'h40, 32'h000000AA, 4'b0001, 32'd0, 1'b0, 0, "wr_lane0");
    transaction(1'b0, 32'h40, 32'd0, 4'b0000, 32'hDEADBEAA, 1'b0, 0, "rd_lane0");
    transaction(1'b1, 32'h40, 32'h11111111, 4'b0000, 32'd0, 1'b0, 0, "wr_be0");
    transaction(1'b0, 32'h40, 32'd0, 4'b0000, 32'hDEADBEAA, 1'b0, 5, "rd_hold");

`ifdef MEM_RESPONDER_CHECK_EN
    $display("[TB] address checking enabled");
    transaction(1'b1, 32'h0, 32'h01020304, 4'b1111, 32'd0, 1'b0, 0, "wr_zero");
    transaction(1'b1, 32'h42, 32'h55555555, 4'b1111, 32'd0, 1'b1, 0, "wr_misal");
    transaction(1'b1, 32'h1000, 32'h66666666, 4'b1111, 32'd0, 1'b1, 0, "wr_range");
    transaction(1'b0, 32'h42, 32'd0, 4'b0000, 32'd0, 1'b1, 0, "rd_misal");
    transaction(1'b0, 32'h40, 32'd0, 4'b0000, 32'hDEADBEAA, 1'b0, 0, "rd_after_err");
    transaction(1'b0, 32'h0, 32'd0, 4'b0000, 32'h01020304, 1'b0, 0, "rd_zero");
`else
    $display("[TB] address wrap");
    transaction(1'b1, 32'h1040, 32'h0BADCAFE, 4'b1111, 32'd0, 1'b0, 0, "wr_wrap");
    transaction(1'b0, 32'h40, 32'd0, 4'b0000, 32'h0BADCAFE, 1'b0, 0, "rd_wrap");
    transaction(1'b0, 32'h43, 32'd0, 4'b0000, 32'h0BADCAFE, 1'b0, 0, "rd_lowbits");
`endif

    $display("[TB] reset during ACCESS");
    transaction(1'b1, 32'h80, 32'hCAFEF00D, 4'b1111, 32'd0, 1'b0, 0, "wr_80");
    applyStimulus(1'b1, 32'h80, 32'h12345678, 4'b1111, "wr_80_abort");
    reset = 1'b0;
    #1;
    checkResetOutputs("reset_access");
    @(negedge clk);
    reset = 1'b1;
    transaction(1'b0, 32'h80, 32'd0, 4'b0000, 32'hCAFEF00D, 1'b0, 0, "rd_80");

    $display("[TB] reset during RESP");
    applyStimulus(1'b1, 32'hC0, 32'h0F0F0F0F, 4'b1111, "wr_c0");
    waitResponse(cycles);
    checkOutput("wr_c0_resp_valid", 32'(bus.rsp_valid), 32'd1);
    reset = 1'b0;
    #1;
    checkResetOutputs("reset_resp");
    @(negedge clk);
    reset = 1'b1;
    transaction(1'b0, 32'hC0, 32'd0, 4'b0000, 32'h0F0F0F0F, 1'b0, 0, "rd_c0");

    $display("[TB] back-to-back reads, LATENCY=1");
    fast_bus.req_valid = 1'b1;
    fast_bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && accepts.size() < 4; cyc++) begin
      if (fast_bus.req_ready) accepts.push_back(cyc);
      @(negedge clk);
    end
    fast_bus.req_valid = 1'b0;
    checkOutput("b2b_accepts", 32'(accepts.size()), 32'd4);
    for (int i = 1; i < accepts.size(); i++) begin
      checkOutput("b2b_spacing", 32'(accepts[i] - accepts[i-1]), 32'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RV32I core. It accepts one word read or write request at a time from the core's address/data path over a valid/ready handshake. It performs the access on an internal word array after a fixed, parameterized latency and returns a response over a second valid/ready handshake. The block sits between the core's memory-address mux and the unified instruction/data storage, and serves instruction fetches, loads and stores.

## Interface
- ADDR_W, 10: word-address bits; array depth is 2^ADDR_W 32-bit words.
- LATENCY, 2: cycles spent in ACCESS per transaction; legal range 1..15.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load/fetch.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i gates byte lane i (bits 8i+7:8i). Ignored on reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  request was misaligned or out of range.
- busy  out  1  high in ACCESS or RESP.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. When req_valid=1, the request is accepted on that edge:
  - latch write, addr, wdata, be;
  - load the counter with LATENCY-1;
  - go to ACCESS.
- ACCESS: req_ready=0. The counter decrements each cycle. On the edge where the counter is 0, the array access happens and the state moves to RESP:
  - read: rsp_rdata <= mem[addr[ADDR_W+1:2]];
  - write: enabled byte lanes are updated, rsp_rdata <= 0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready. On that edge the state returns to IDLE and rsp_valid drops.
- Request inputs are sampled only on the accept edge. Changes to them in ACCESS or RESP are ignored.
- A write with req_be=0000 completes normally and leaves the array unchanged.
- Array contents are not reset.

## Timing
- Reset values (asserted asynchronously): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter 0.
- Accept edge A. rsp_valid goes high after edge A+LATENCY. With rsp_ready held at 1, the response handshake completes at edge A+LATENCY+1.
- Minimum spacing between accepts is LATENCY+2 cycles. IDLE always lasts at least one cycle after RESP, so there is no request accept in the same cycle as a response handshake.
- Reset asserted in ACCESS: a write not yet committed is dropped and the array is unchanged; the state goes to IDLE.
- Reset asserted in RESP: the response is discarded; a write already committed stays.
- Read and write to the same address in consecutive transactions: the read returns the newly written data.

## Configuration
- MEM_RESPONDER_CHECK_EN defined:
  - rsp_err=1 when addr[1:0]!=0 or addr[31:ADDR_W+2]!=0;
  - an erroring write does not modify the array;
  - an erroring read returns rsp_rdata=0;
  - timing is identical to a normal access.
- Not defined:
  - rsp_err is tied to 0;
  - addr[1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo the array depth.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x40 with be=1111, then read 0x40 (LATENCY=2) -> rsp_valid 2 cycles after each accept; read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write 0x000000AA to 0x40 with be=0001, then read 0x40 -> 0xDEADBEAA.
- Hold rsp_ready=0 for 5 cycles in RESP, then raise it -> rsp_valid and rsp_rdata stable throughout; req_ready=0 until one cycle after the handshake.
- With the check macro on, write to 0x42 and to 0x00001000 (ADDR_W=10) -> rsp_err=1 for both, array unchanged; a read of 0x40 still returns 0xDEADBEAA.
- Drop reset low in the first ACCESS cycle of a write of 0x12345678 to 0x80 -> outputs at reset values immediately; a later read of 0x80 returns the previous contents.
- LATENCY=1, four back-to-back reads with req_valid held high -> accepts exactly 3 cycles apart.
